// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Double-buffered digit codes, leading-zero blanking and a dead-time gap between digits.
module seg7_scan_ctrl #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [NDIG-1:0]   an_out,
  output logic              frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 2) ? $clog2(NDIG) : 1;
  localparam int unsigned VW = 4 * NDIG;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {OFF, SHOW, GAP} scanState;

  scanState       state, stateNext;
  logic [IW-1:0]  idx, idxNext;
  logic [CW-1:0]  cnt, cntNext;
  logic [VW-1:0]  pendVal, pendValNext, shVal, shValNext;
  logic [NDIG-1:0] pendDp, pendDpNext, shDp, shDpNext;
  logic           pendValid, pendValidNext;
  logic           commit;
  logic [6:0]     segNext;
  logic           dpNext, frameDoneNext;
  logic [NDIG-1:0] anNext, blankDig;
  logic [3:0]     code;
  logic           dpSel, blankSel, allZero;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes are dark.
  function automatic logic [6:0] segEncode(input logic [3:0] c);
    case (c)
      4'd0:    segEncode = 7'b1000000;
      4'd1:    segEncode = 7'b1111001;
      4'd2:    segEncode = 7'b0100100;
      4'd3:    segEncode = 7'b0110000;
      4'd4:    segEncode = 7'b0011001;
      4'd5:    segEncode = 7'b0010010;
      4'd6:    segEncode = 7'b0000010;
      4'd7:    segEncode = 7'b1111000;
      4'd8:    segEncode = 7'b0000000;
      4'd9:    segEncode = 7'b0010000;
      default: segEncode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      pendVal    <= '0;
      pendDp     <= '0;
      pendValid  <= 1'b0;
      shVal      <= '1;
      shDp       <= '0;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= stateNext;
      idx        <= idxNext;
      cnt        <= cntNext;
      pendVal    <= pendValNext;
      pendDp     <= pendDpNext;
      pendValid  <= pendValidNext;
      shVal      <= shValNext;
      shDp       <= shDpNext;
      seg_out    <= segNext;
      dp_out     <= dpNext;
      an_out     <= anNext;
      frame_done <= frameDoneNext;
    end
  end

  // Outputs are computed from the next state so they switch on the same edge.
  always_comb begin
    stateNext     = state;
    idxNext       = idx;
    cntNext       = cnt;
    commit        = 1'b0;
    pendValNext   = pendVal;
    pendDpNext    = pendDp;
    pendValidNext = pendValid;
    shValNext     = shVal;
    shDpNext      = shDp;
    segNext       = 7'h7F;
    dpNext        = 1'b1;
    anNext        = '1;
    frameDoneNext = 1'b0;
    code          = 4'h0;
    dpSel         = 1'b0;
    blankSel      = 1'b0;
    allZero       = 1'b1;
    blankDig      = '0;

    case (state)
      OFF: begin
        idxNext = '0;
        cntNext = '0;
        if (enable) begin
          stateNext = SHOW;
          commit    = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          stateNext = GAP;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      GAP: begin
        stateNext = SHOW;
        if (idx == IDX_LAST) begin
          idxNext = '0;
          commit  = 1'b1;
        end else begin
          idxNext = idx + IW'(1);
        end
      end
      default: stateNext = OFF;
    endcase

    if (!enable) begin
      stateNext = OFF;
      idxNext   = '0;
      cntNext   = '0;
      commit    = 1'b0;
    end

    frameDoneNext = (stateNext == GAP) && (idx == IDX_LAST);

    // A load landing on a commit edge bypasses pending straight into shadow.
    if (commit) begin
      if (load) begin
        shValNext = value;
        shDpNext  = dp_in;
      end else if (pendValid) begin
        shValNext = pendVal;
        shDpNext  = pendDp;
      end
      pendValidNext = 1'b0;
    end else if (load) begin
      pendValNext   = value;
      pendDpNext    = dp_in;
      pendValidNext = 1'b1;
    end

    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      allZero     = allZero && (shValNext[4*k +: 4] == 4'h0);
      blankDig[k] = blank_lz && allZero && (k != 0);
    end

    if (stateNext == SHOW) begin
      for (int k = 0; k < int'(NDIG); k++) begin
        if (idxNext == IW'(k)) begin
          code      = shValNext[4*k +: 4];
          dpSel     = shDpNext[k];
          blankSel  = blankDig[k];
          anNext[k] = 1'b0;
        end
      end
      segNext = blankSel ? 7'h7F : segEncode(code);
      dpNext  = ~dpSel;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-arithmetic reference model queues the
// expected outputs for every cycle and a monitor pops and compares them.
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int FRAME = NDIG * (DIV + 1);

  logic              clk, rst_n, enable, load, blank_lz;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp_in;
  logic [6:0]        seg_out;
  logic              dp_out, frame_done;
  logic [NDIG-1:0]   an_out;

  typedef struct packed {
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp;
    logic            fd;
  } expT;

  expT q[$];
  int total = 0;
  int bad = 0;

  logic [6:0]        segTab [16];
  logic [4*NDIG-1:0] mShVal, mPendVal;
  logic [NDIG-1:0]   mShDp, mPendDp;
  bit                mPendValid, mOn;
  int                mt;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: position within the frame decides digit, gap and frame_done.
  task automatic modelStep();
    expT e;
    bit commitNow, allZ;
    int p, d, ph;
    logic [3:0] c;
    e = '{an: '1, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    if (!rst_n) begin
      mOn = 0; mt = 0; mShVal = '1; mShDp = '0; mPendValid = 0;
      q.push_back(e);
      return;
    end
    commitNow = 0;
    if (!enable) mOn = 0;
    else if (!mOn) begin mOn = 1; mt = 0; commitNow = 1; end
    else begin mt = (mt + 1) % FRAME; commitNow = (mt == 0); end
    if (commitNow) begin
      if (load) begin mShVal = value; mShDp = dp_in; end
      else if (mPendValid) begin mShVal = mPendVal; mShDp = mPendDp; end
      mPendValid = 0;
    end else if (load) begin
      mPendVal = value; mPendDp = dp_in; mPendValid = 1;
    end
    if (mOn) begin
      p = mt; d = p / (DIV + 1); ph = p % (DIV + 1);
      if (ph < DIV) begin
        c = mShVal[4*d +: 4];
        allZ = 1;
        for (int k = d; k < NDIG; k++) if (mShVal[4*k +: 4] != 4'h0) allZ = 0;
        e.an[d] = 1'b0;
        e.seg = (blank_lz && d > 0 && allZ) ? 7'h7F : segTab[c];
        e.dp = ~mShDp[d];
      end else begin
        e.fd = (d == NDIG - 1);
      end
    end
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    load = 1'b0;
  endtask

  task automatic waitPos(input int pos);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (mOn && mt == pos) hit = 1;
      else tick();
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL waitPos: frame position %0d not reached within 200 cycles (model pos %0d)", pos, mt);
    end
  endtask

  initial begin
    expT got, ex;
    segTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
               7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    mShVal = '1; mShDp = '0; mPendVal = '0; mPendDp = '0; mPendValid = 0; mOn = 0; mt = 0;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (q.size() > 0) begin
          ex = q.pop_front();
          got = '{an: an_out, seg: seg_out, dp: dp_out, fd: frame_done};
          total++;
          if (got !== ex) begin
            bad++;
            $display("FAIL scan @%0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                     $time, got.an, got.seg, got.dp, got.fd, ex.an, ex.seg, ex.dp, ex.fd);
          end
        end
      end
    join_none

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    value = 16'h4321; dp_in = '0; load = 1'b1; tick();
    enable = 1'b1;
    repeat (2 * FRAME) tick();

    waitPos(7);
    value = 16'h9876; load = 1'b1; tick();
    repeat (2 * FRAME) tick();

    waitPos(FRAME - 1);
    value = 16'h1357; load = 1'b1; tick();
    repeat (FRAME) tick();

    waitPos(3);
    value = 16'h1111; load = 1'b1; tick(); tick();
    value = 16'h2222; load = 1'b1; tick();
    repeat (FRAME + 2) tick();

    blank_lz = 1'b1; value = 16'h0070; load = 1'b1; tick();
    repeat (2 * FRAME) tick();
    value = 16'h0000; load = 1'b1; tick();
    repeat (2 * FRAME) tick();
    blank_lz = 1'b0;
    repeat (FRAME) tick();

    value = 16'hFA05; dp_in = 4'b0010; load = 1'b1; tick();
    repeat (2 * FRAME) tick();

    waitPos(2 * (DIV + 1) + 1);
    enable = 1'b0; tick();
    value = 16'h5555; dp_in = 4'b0001; load = 1'b1; tick(); tick();
    enable = 1'b1;
    repeat (FRAME) tick();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        load = 1'b1;
        value = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom & 32'h00FF);
        dp_in = 4'($urandom);
      end
      if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
      enable = ($urandom_range(39) != 0);
      tick();
    end

    enable = 1'b1;
    waitPos(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({an_out, seg_out, dp_out, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
               an_out, seg_out, dp_out, frame_done);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (FRAME) tick();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds a double-buffered set of 4-bit digit codes and scans them one digit at a time. The shared segment bus is driven through the team's standard active-low 0–9 segment encoding. It sits between counter/datapath logic that produces BCD values and the board's shared segment and anode pins, and inserts a dead-time gap between digits to suppress ghosting.

## Interface
- NDIG, 8: number of digits scanned (2..8).
- DIV, 50000: clock cycles each digit is lit per visit (≥2).
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan, 0 = display dark.
- load  in  1  single-cycle strobe: capture value/dp_in into pending buffer.
- value  in  4*NDIG  digit codes; value[3:0] is digit 0 (least significant, rightmost).
- dp_in  in  NDIG  decimal-point request per digit, 1 = lit.
- blank_lz  in  1  1 = blank leading zeros.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1  decimal point, active-low.
- an_out  out  NDIG  digit anode enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse when the last digit's gap completes.

## Operation
- Buffers: pending (value, dp, valid flag) written on load. Shadow (value, dp) drives the display. Shadow copies pending only at a commit point, then valid clears. Commit points: frame wrap, and OFF→SHOW entry.
- Load in a commit cycle: shadow takes the new load data directly, and valid stays 0.
- Load while valid=1: overwrites pending, last load wins.
- Segment encoding (active-low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10–15 give 1111111 (blank).
- Leading-zero blanking (blank_lz=1): digit k is blank when its code is 0 and all digits above k are 0. Digit 0 is never blanked by this rule. dp is unaffected by blanking.
- FSM states:
  - OFF: an_out all 1, seg_out 7F, dp_out 1. Index and counter are 0. On enable=1 → SHOW, with commit.
  - SHOW: an_out[idx]=0, seg/dp from shadow digit idx. Counter counts 0..DIV-1. At DIV-1 → GAP.
  - GAP: one cycle; an_out all 1, seg_out 7F, dp_out 1. Then idx advances and the state returns to SHOW. When idx was NDIG-1, idx wraps to 0, frame_done pulses in this GAP cycle, and a commit occurs.
- enable=0 in any state: go to OFF on the next edge. Counter and idx clear. Pending contents are retained.
- Width rules: counter is clog2(DIV) bits; idx is clog2(NDIG) bits (min 1). Index wraps only at NDIG-1, so non-power-of-2 NDIG never selects a nonexistent digit.

## Timing
- All outputs are registered and change on the same edge as the state/idx transition. There is no combinational path from inputs to outputs.
- Reset values: seg_out=7'b1111111, dp_out=1, an_out=all 1, frame_done=0. State is OFF, idx=0, counter=0, shadow codes all 4'hF with dp 0, and pending valid=0.
- Reset mid-scan returns all outputs to their reset values asynchronously.
- Per digit: DIV SHOW cycles, then 1 GAP cycle. Frame = NDIG*(DIV+1) cycles.
- Enable rises at edge t: digit 0 is lit from edge t+1.
- Load-to-visible latency: at most one frame plus 1 cycle. New data appears first on digit 0.
- No overlap: an anode never goes low in the same cycle another is released. The GAP cycle always separates them.

## Test plan
- Reset/idle: with rst_n low, or enable=0 after reset → seg_out=7F, an_out=all 1, dp_out=1, frame_done=0. Drop rst_n mid-SHOW → outputs return to reset values immediately.
- Basic scan (NDIG=4, DIV=4): load value=16'h4321, dp_in=0, enable=1 → an_out sequence 1110×4, 1111, 1101×4, 1111 … Segment pattern is 1111001 for digit 0, then 0100100, 0110000, 0011001. frame_done pulses every 20 cycles.
- Double-buffer: mid-frame, load 16'h9876 → the current frame continues showing 4321. After the frame_done cycle, digit 0 shows 0000010 (6). The load coinciding with the GAP-wrap cycle appears in the immediately following frame.
- Leading zeros: value=16'h0070 with blank_lz=1 → digits 3 and 2 blank (7F), digit 1 shows 1111000, digit 0 shows 1000000. With value=16'h0000, only digit 0 shows 1000000. With blank_lz=0, all digits show 1000000.
- Invalid codes and dp: value=16'hFA05, dp_in=4'b0010 → digit 0 shows 0010010. Digit 1 shows 1000000 with dp_out=0. Digits 2 and 3 show 7F.
- Enable toggle: deassert enable during digit 2's SHOW → next edge all anodes high. Reassert → digit 0 lit one cycle later with pending data committed.
